// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch states, opcode values and instruction lengths
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OP,
    LO,
    HI,
    HOLD
  } fetch_state_t;

  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_ADC_ABS = 8'h6D;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_NOP     = 8'hEA;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

endpackage

// File: rtl/opcode_decoder.sv
// rtl/opcode_decoder.sv - combinational opcode to class strobes, length and illegal flag
module opcode_decoder
  import fetch_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       load,
  output logic       store,
  output logic       branch,
  output logic       arith_imm,
  output logic       arith_mem,
  output logic       illegal,
  output logic [1:0] length
);

  always_comb begin
    load      = 1'b0;
    store     = 1'b0;
    branch    = 1'b0;
    arith_imm = 1'b0;
    arith_mem = 1'b0;
    illegal   = 1'b0;
    length    = LEN_1;
    case (opcode)
      OP_ADC_IMM: begin arith_imm = 1'b1; length = LEN_2; end
      OP_ADC_ABS: begin arith_mem = 1'b1; length = LEN_3; end
      OP_LDA_ABS: begin load      = 1'b1; length = LEN_3; end
      OP_STA_ABS: begin store     = 1'b1; length = LEN_3; end
      OP_JMP_ABS: begin branch    = 1'b1; length = LEN_3; end
      OP_NOP:     length = LEN_1;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - byte-serial instruction fetch, PC ownership and decode
module instr_fetch_decode
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0200
) (
  input  logic              clka,
  input  logic              restart_n,
  input  logic              fetch_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              instr_valid,
  input  logic              instr_ack,
  output logic [7:0]        opcode,
  output logic [15:0]       operand,
  output logic              load,
  output logic              store,
  output logic              branch,
  output logic              arith_imm,
  output logic              arith_mem,
  output logic              illegal,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [7:0]        opcode_next;
  logic [15:0]       operand_next;

  logic [7:0] dec_in;
  logic       d_load;
  logic       d_store;
  logic       d_branch;
  logic       d_arith_imm;
  logic       d_arith_mem;
  logic       d_illegal;
  logic [1:0] d_len;

  // In OP the length of the byte arriving now picks the next state; elsewhere decode the held opcode.
  assign dec_in = (state == OP) ? mem_rdata : opcode;

  opcode_decoder u_dec (
    .opcode    (dec_in),
    .load      (d_load),
    .store     (d_store),
    .branch    (d_branch),
    .arith_imm (d_arith_imm),
    .arith_mem (d_arith_mem),
    .illegal   (d_illegal),
    .length    (d_len)
  );

  always_ff @(posedge clka) begin
    if (!restart_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      opcode  <= '0;
      operand <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      opcode  <= opcode_next;
      operand <= operand_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    opcode_next  = opcode;
    operand_next = operand;
    mem_rd       = 1'b0;
    instr_valid  = 1'b0;
    case (state)
      IDLE: if (fetch_en) state_next = OP;
      OP: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          opcode_next  = mem_rdata;
          operand_next = '0;
          pc_next      = pc + ADDR_W'(1);
          state_next   = (d_len == LEN_1) ? HOLD : LO;
        end
      end
      LO: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          operand_next[7:0] = mem_rdata;
          pc_next           = pc + ADDR_W'(1);
          state_next        = (d_len == LEN_2) ? HOLD : HI;
        end
      end
      HI: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          operand_next[15:8] = mem_rdata;
          pc_next            = pc + ADDR_W'(1);
          state_next         = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ack) state_next = OP;
      end
      default: state_next = IDLE;
    endcase
    // A redirect overrides any completion or ack in the same cycle and drops partial bytes.
    if (pc_load) begin
      pc_next      = pc_target;
      opcode_next  = opcode;
      operand_next = operand;
      if (state != IDLE) state_next = OP;
    end
  end

  assign mem_addr  = pc;
  assign load      = d_load      & instr_valid;
  assign store     = d_store     & instr_valid;
  assign branch    = d_branch    & instr_valid;
  assign arith_imm = d_arith_imm & instr_valid;
  assign arith_mem = d_arith_mem & instr_valid;
  assign illegal   = d_illegal   & instr_valid;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - scoreboard bench for instr_fetch_decode
module tb_instr_fetch_decode;

  logic        clka = 1'b0;
  logic        restart_n, fetch_en, mem_rd, mem_ready, instr_valid, instr_ack;
  logic [15:0] mem_addr, operand, pc_target, pc;
  logic [7:0]  mem_rdata, opcode;
  logic        load, store, branch, arith_imm, arith_mem, illegal, pc_load;

  always #5 clka = ~clka;

  instr_fetch_decode dut (
    .clka(clka), .restart_n(restart_n), .fetch_en(fetch_en),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .instr_valid(instr_valid), .instr_ack(instr_ack), .opcode(opcode), .operand(operand),
    .load(load), .store(store), .branch(branch), .arith_imm(arith_imm), .arith_mem(arith_mem),
    .illegal(illegal), .pc_load(pc_load), .pc_target(pc_target), .pc(pc)
  );

  typedef struct {
    logic [7:0]  op;
    logic [15:0] opnd;
    logic [4:0]  cls;
    logic        ill;
    logic [15:0] pc_after;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [0:65535];
  int         tests = 0;
  int         failures = 0;
  int         wait_fixed;
  bit         ack_rand;
  int         ack_hold;

  // Instruction table: class bits are {load,store,branch,arith_imm,arith_mem}.
  logic [7:0] tbl_op  [6] = '{8'h69, 8'h6D, 8'hAD, 8'h8D, 8'h4C, 8'hEA};
  logic [4:0] tbl_cls [6] = '{5'b00010, 5'b00001, 5'b10000, 5'b01000, 5'b00100, 5'b00000};
  int         tbl_len [6] = '{2, 3, 3, 3, 3, 1};

  function void chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  task automatic fail_now(input string name);
    tests++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic place(input logic [15:0] a, input logic [7:0] op, input logic [7:0] lo,
                       input logic [7:0] hi, input bit expect_it, output logic [15:0] nxt);
    exp_t        e;
    int          len;
    logic [15:0] a1, a2;
    len   = 1;
    e.cls = '0;
    e.ill = 1'b1;
    for (int i = 0; i < 6; i++)
      if (tbl_op[i] == op) begin
        len   = tbl_len[i];
        e.cls = tbl_cls[i];
        e.ill = 1'b0;
      end
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    mem[a] = op;
    if (len >= 2) mem[a1] = lo;
    if (len == 3) mem[a2] = hi;
    e.op       = op;
    e.opnd     = (len == 1) ? 16'h0000 : (len == 2) ? {8'h00, lo} : {hi, lo};
    nxt        = a + 16'(len);
    e.pc_after = nxt;
    if (expect_it) sb.push_back(e);
  endtask

  task automatic wait_addr(input logic [15:0] target, input int bound, input string name);
    int c = 0;
    while (!(mem_rd === 1'b1 && mem_addr === target) && c < bound) begin
      @(negedge clka);
      c++;
    end
    if (!(mem_rd === 1'b1 && mem_addr === target)) fail_now(name);
  endtask

  // Memory responder: fixed or random wait states per byte.
  initial begin
    int need;
    bit pend;
    pend = 0; need = 0; mem_ready = 1'b0; mem_rdata = 8'h00;
    forever begin
      @(negedge clka);
      mem_rdata = mem[mem_addr];
      if (mem_rd === 1'b1) begin
        if (!pend) begin
          pend = 1;
          need = (wait_fixed < 0) ? int'($urandom_range(0, 2)) : wait_fixed;
        end
        if (need == 0) begin mem_ready = 1'b1; pend = 0; end
        else begin mem_ready = 1'b0; need--; end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        pend = 0;
      end
    end
  end

  // Consumer: acks after a programmed hold, and sprinkles stray acks while nothing is valid.
  initial begin
    int held, hold_now;
    held = 0; hold_now = 0; instr_ack = 1'b0;
    forever begin
      @(negedge clka);
      if (instr_valid === 1'b1) begin
        if (held == 0) hold_now = ack_rand ? int'($urandom_range(0, 3)) : ack_hold;
        instr_ack = (hold_now >= 0 && held >= hold_now);
        held++;
      end else begin
        held = 0;
        instr_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: pops the scoreboard on each new instruction and checks hold behaviour.
  initial begin
    exp_t        e;
    bit          prev;
    logic [29:0] snap;
    logic [4:0]  cls_now;
    prev = 0; snap = '0;
    forever begin
      @(negedge clka);
      cls_now = {load, store, branch, arith_imm, arith_mem};
      if (instr_valid !== 1'b1) chk("strobes_gated", {cls_now, illegal}, 0);
      if (instr_valid === 1'b1 && !prev) begin
        if (sb.size() == 0) begin
          tests++;
          failures++;
          $display("FAIL unexpected_instr: got opcode %0h at pc %0h, required none", opcode, pc);
        end else begin
          e = sb.pop_front();
          chk("opcode", opcode, e.op);
          chk("operand", operand, e.opnd);
          chk("class", cls_now, e.cls);
          chk("illegal", illegal, e.ill);
          chk("pc_after", pc, e.pc_after);
        end
        snap = {opcode, operand, cls_now, illegal};
      end else if (instr_valid === 1'b1) begin
        chk("hold_stable", {opcode, operand, cls_now, illegal}, snap);
      end
      if (instr_valid === 1'b1) begin
        chk("no_prefetch", mem_rd, 0);
        chk("onehot", ($countones(cls_now) <= 1), 1);
      end
      prev = (instr_valid === 1'b1);
    end
  end

  initial begin
    logic [15:0] a, nxt, tail;
    logic [7:0]  op;
    int          k, lat, n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    restart_n = 1'b0; fetch_en = 1'b0; pc_load = 1'b0; pc_target = '0;
    wait_fixed = 0; ack_rand = 0; ack_hold = 5;

    place(16'h0200, 8'h69, 8'h05, 8'h00, 1, nxt);
    place(16'h0202, 8'hAD, 8'h34, 8'h12, 1, nxt);
    place(16'h0205, 8'h4C, 8'h00, 8'h30, 1, nxt);
    place(16'h0208, 8'h8D, 8'h77, 8'h66, 0, nxt);
    place(16'h3000, 8'hFF, 8'h00, 8'h00, 1, a);
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 6);
      op = (k < 6) ? tbl_op[k] : 8'($urandom);
      place(a, op, 8'($urandom), 8'($urandom), 1, nxt);
      a = nxt;
    end
    tail = a;
    place(tail, 8'hAD, 8'h11, 8'h22, 0, nxt);

    repeat (2) @(negedge clka);
    chk("rst_valid", instr_valid, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_pc", pc, 16'h0200);
    chk("rst_addr", mem_addr, 16'h0200);
    chk("rst_opcode", opcode, 0);
    chk("rst_operand", operand, 0);

    restart_n = 1'b1; fetch_en = 1'b1;
    @(negedge clka);
    fetch_en = 1'b0;
    chk("adc_op_rd", mem_rd, 1);
    chk("adc_op_addr", mem_addr, 16'h0200);
    @(negedge clka);
    chk("adc_lo_addr", mem_addr, 16'h0201);
    @(negedge clka);
    chk("adc_latency", instr_valid, 1);
    wait_fixed = 2;

    wait_addr(16'h0202, 40, "lda_start");
    lat = 0;
    while (instr_valid !== 1'b1 && lat < 30) begin @(negedge clka); lat++; end
    chk("lda_latency", lat, 9);
    wait_fixed = 0;

    wait_addr(16'h0205, 40, "jmp_start");
    n = 0;
    while (instr_valid !== 1'b1 && n < 30) begin @(negedge clka); n++; end
    n = 0;
    while (instr_valid === 1'b1 && n < 30) begin @(negedge clka); n++; end
    chk("jmp_hold_cycles", n, 6);
    chk("after_ack_rd", mem_rd, 1);
    chk("after_ack_addr", mem_addr, 16'h0208);

    wait_addr(16'h020A, 20, "sta_hi");
    pc_load = 1'b1; pc_target = 16'h3000;
    @(negedge clka);
    pc_load = 1'b0;
    chk("redirect_addr", mem_addr, 16'h3000);
    chk("redirect_valid", instr_valid, 0);
    chk("redirect_rd", mem_rd, 1);

    ack_rand = 1; wait_fixed = -1;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin @(negedge clka); n++; end
    if (sb.size() != 0) fail_now("random_drain");
    wait_fixed = 0; ack_rand = 0;

    wait_addr(tail + 16'd1, 100, "tail_lo");
    restart_n = 1'b0;
    @(negedge clka);
    restart_n = 1'b1;
    chk("restart_valid", instr_valid, 0);
    chk("restart_pc", pc, 16'h0200);
    chk("restart_opcode", opcode, 0);
    chk("restart_rd", mem_rd, 0);

    ack_hold = -1;
    place(16'hFFFF, 8'hEA, 8'h00, 8'h00, 1, nxt);
    pc_load = 1'b1; pc_target = 16'hFFFF;
    @(negedge clka);
    pc_load = 1'b0;
    chk("idle_redirect_pc", pc, 16'hFFFF);
    chk("idle_redirect_rd", mem_rd, 0);
    fetch_en = 1'b1;
    @(negedge clka);
    fetch_en = 1'b0;
    n = 0;
    while (instr_valid !== 1'b1 && n < 10) begin @(negedge clka); n++; end
    chk("pc_wrap", pc, 16'h0000);
    @(negedge clka);
    chk("sb_drained", sb.size(), 0);

    restart_n = 1'b0;
    repeat (2) @(negedge clka);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
